// File: rtl/stitch_pipeline_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stitch_pipeline_pkg
//  Brief    : Shared defaults and helper functions for the ready/valid
//             stitched pipeline wrapper and its per-slot sub-module.
//  Revision : 1.0  initial release
// ============================================================================
package stitch_pipeline_pkg;

    localparam int c_default_width      = 32;
    localparam int c_default_num_stages = 2;

    // Constant added by stage i: 2^i, or 0 once the bit falls outside the word.
    // A negative index means "no stage in front of this slot" (the input slot).
    function automatic logic [63:0] stage_inc(input int i, input int width);
        if ((i < 0) || (i >= width) || (i >= 64)) begin
            return 64'd0;
        end
        return 64'd1 << i;
    endfunction

    // Cycles from input acceptance to the word appearing on the output.
    function automatic int total_latency(input int n);
        return n + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stitch_pipeline_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stitch_pipeline_stage
//  Brief    : One pipeline register slot with the combinational stage add on
//             its input side. STAGE_IDX < 0 gives a plain capture register.
//  Revision : 1.0  initial release
// ============================================================================
module stitch_pipeline_stage
    import stitch_pipeline_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int STAGE_IDX = -1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_slot_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [WIDTH-1:0] c_inc = WIDTH'(stage_inc(STAGE_IDX, WIDTH));

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_sum;

    // Stage function; the carry out of the top bit is intentionally dropped.
    assign w_sum = i_up_data + c_inc;

    // Valid bit: follows upstream valid whenever this slot is allowed to load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_slot_ready) begin
            r_valid <= i_up_valid;
        end
    end

    // Data register: only overwritten by a real word, no reset needed.
    always_ff @(posedge clk) begin
        if (i_slot_ready && i_up_valid) begin
            r_data <= w_sum;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/stitch_pipeline_rv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stitch_pipeline_rv
//  Brief    : Parametrised stitched pipeline with ready/valid backpressure.
//             NUM_STAGES combinational stages, NUM_STAGES+1 register slots,
//             end-to-end result out = x + (2^NUM_STAGES - 1).
//             Optional macro STITCH_PIPELINE_RV_STATS_EN adds the 32-bit
//             xfer_count / stall_count outputs.
//  Revision : 1.0  initial release
// ============================================================================
module stitch_pipeline_rv
    import stitch_pipeline_pkg::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int NUM_STAGES = c_default_num_stages   // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] x,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [WIDTH-1:0] out
`ifdef STITCH_PIPELINE_RV_STATS_EN
    ,
    output logic [31:0]      xfer_count,
    output logic [31:0]      stall_count
`endif
);

    logic [NUM_STAGES:0] w_slot_valid;
    logic [NUM_STAGES:0] w_slot_ready;
    logic [WIDTH-1:0]    w_slot_data [NUM_STAGES+1];

    // Ready chain from the output back to the input: a slot may load if it is
    // empty or if everything downstream of it moves this cycle.
    always_comb begin
        w_slot_ready[NUM_STAGES] = !w_slot_valid[NUM_STAGES] || output_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            w_slot_ready[k] = !w_slot_valid[k] || w_slot_ready[k+1];
        end
    end

    for (genvar k = 0; k <= NUM_STAGES; k++) begin : g_slot
        if (k == 0) begin : g_head
            stitch_pipeline_stage #(
                .WIDTH     (WIDTH),
                .STAGE_IDX (-1)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .i_up_valid   (input_valid),
                .i_up_data    (x),
                .i_slot_ready (w_slot_ready[k]),
                .o_valid      (w_slot_valid[k]),
                .o_data       (w_slot_data[k])
            );
        end else begin : g_body
            stitch_pipeline_stage #(
                .WIDTH     (WIDTH),
                .STAGE_IDX (k - 1)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .i_up_valid   (w_slot_valid[k-1]),
                .i_up_data    (w_slot_data[k-1]),
                .i_slot_ready (w_slot_ready[k]),
                .o_valid      (w_slot_valid[k]),
                .o_data       (w_slot_data[k])
            );
        end
    end

    assign input_ready  = w_slot_ready[0];
    assign output_valid = w_slot_valid[NUM_STAGES];
    assign out          = w_slot_data[NUM_STAGES];

`ifdef STITCH_PIPELINE_RV_STATS_EN
    logic [31:0] r_xfer_count;
    logic [31:0] r_stall_count;

    // Output-side statistics: handshakes and cycles stalled by the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_count  <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (output_valid && output_ready) begin
                r_xfer_count <= r_xfer_count + 32'd1;
            end
            if (output_valid && !output_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign xfer_count  = r_xfer_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
